dac_frame_sequencer: RTL and testbench

- Sequences the dual-channel 12-bit DAC path downstream of the waveform generators.
- On each sampling tick, snapshots the channel A and channel B DAC words and serialises two 16-bit command frames to an external dual SPI DAC (A frame first, then B).
- Then pulses LDAC so both channels update simultaneously.
- Sole owner of the shared SPI bus; reports tick overruns to the AXI register block.

---
 rtl/dac_seq_pkg.sv | 51 +++++
 rtl/spi_frame_tx.sv | 114 +++++++++++
 rtl/dac_frame_sequencer.sv | 152 +++++++++++++++
 tb/tb_dac_frame_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_seq_pkg.sv
// Shared state encodings, frame layout and frame builder for the DAC frame sequencer.
package dac_seq_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned DATA_W   = 12;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned BIT_W    = 4;

  localparam int unsigned CH_BIT   = 15;
  localparam int unsigned GA_BIT   = 13;
  localparam int unsigned SHDN_BIT = 12;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  // SPI line phases; the frame transmitter walks IDLE/SETUP/SHIFT/HOLD.
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP,
    LDAC
  } state_t;

  // Sequencer phases for one sampling tick.
  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_FRAME_A,
    SEQ_GAP,
    SEQ_FRAME_B,
    SEQ_LDAC
  } seq_t;

  // A disabled channel is sent as a shutdown command with a zeroed data field.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              ch,
    input logic              en,
    input logic [DATA_W-1:0] word,
    input logic              ga
  );
    logic [FRAME_W-1:0] f;
    f                 = '0;
    f[CH_BIT]         = ch;
    f[GA_BIT]         = ga;
    f[SHDN_BIT]       = en;
    f[DATA_W-1:0]     = en ? word : '0;
    return f;
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Serialises one 16-bit frame as SPI mode 0 with CS setup and hold of one SCK half-period each.
module spi_frame_tx
  import dac_seq_pkg::*;
#(
  parameter int unsigned SCK_DIV = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  output logic               spi_cs_n,
  output logic               spi_sck,
  output logic               spi_mosi,
  output logic               done_c
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(FRAME_W - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d;
  logic [BIT_W-1:0]   bcnt_q, bcnt_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic               cs_n_d, sck_d, mosi_d;
  logic               half_end;

  assign half_end = (hcnt_q == HALF_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hcnt_q   <= '0;
      bcnt_q   <= '0;
      sreg_q   <= '0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      bcnt_q   <= bcnt_d;
      sreg_q   <= sreg_d;
      spi_cs_n <= cs_n_d;
      spi_sck  <= sck_d;
      spi_mosi <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q + CNT_W'(1);
    bcnt_d  = bcnt_q;
    sreg_d  = sreg_q;
    cs_n_d  = spi_cs_n;
    sck_d   = spi_sck;
    mosi_d  = spi_mosi;
    done_c  = 1'b0;

    case (state_q)
      IDLE: begin
        hcnt_d = '0;
        if (start) begin
          state_d = SETUP;
          bcnt_d  = '0;
          sreg_d  = frame;
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = frame[FRAME_W-1];
        end
      end

      SETUP: begin
        if (half_end) begin
          state_d = SHIFT;
          hcnt_d  = '0;
        end
      end

      // Next bit is presented as SCK falls, so MOSI only moves at the start of a low phase.
      SHIFT: begin
        if (half_end) begin
          hcnt_d = '0;
          sck_d  = ~spi_sck;
          if (spi_sck) begin
            bcnt_d = bcnt_q + BIT_W'(1);
            sreg_d = sreg_q << 1;
            mosi_d = sreg_d[FRAME_W-1];
            if (bcnt_q == BIT_LAST) begin
              state_d = HOLD;
            end
          end
        end
      end

      HOLD: begin
        if (half_end) begin
          state_d = IDLE;
          hcnt_d  = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_c  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cs_n_d  = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/dac_frame_sequencer.sv
// Per sampling tick, sends channel A then channel B frames to a dual SPI DAC and pulses LDAC;
// ticks arriving while a sequence is in flight are dropped and counted.
module dac_frame_sequencer
  import dac_seq_pkg::*;
#(
  parameter int unsigned SCK_DIV = 5,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned LDAC_W  = 3,
  parameter int unsigned GAIN_1X = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_sampling,
  input  logic              enableA,
  input  logic              enableB,
  input  logic [DATA_W-1:0] dacA_word,
  input  logic [DATA_W-1:0] dacB_word,
  input  logic              ovr_clr,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              dac_ldac_n,
  output logic              busy,
  output logic              overrun,
  output logic [CNT_W-1:0]  ovr_count
);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] LDAC_LEN  = CNT_W'(LDAC_W);
  localparam logic [CNT_W-1:0] LDAC_LAST = CNT_W'(LDAC_W + 1);
  localparam logic [CNT_W-1:0] OVR_MAX   = '1;
  localparam logic             GA        = 1'(GAIN_1X);

  seq_t               seq_q, seq_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_b_q, frame_b_d;
  logic               busy_d, ldac_n_d, overrun_d;
  logic [CNT_W-1:0]   ovr_count_d;
  logic               tx_start_c, tx_done_c, tick_drop_c;
  logic [FRAME_W-1:0] tx_frame_c;

  spi_frame_tx #(
    .SCK_DIV (SCK_DIV)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (tx_start_c),
    .frame    (tx_frame_c),
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .done_c   (tx_done_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= SEQ_IDLE;
      cnt_q      <= '0;
      frame_b_q  <= '0;
      busy       <= 1'b0;
      dac_ldac_n <= 1'b1;
      overrun    <= 1'b0;
      ovr_count  <= '0;
    end else begin
      seq_q      <= seq_d;
      cnt_q      <= cnt_d;
      frame_b_q  <= frame_b_d;
      busy       <= busy_d;
      dac_ldac_n <= ldac_n_d;
      overrun    <= overrun_d;
      ovr_count  <= ovr_count_d;
    end
  end

  always_comb begin
    seq_d       = seq_q;
    cnt_d       = cnt_q;
    frame_b_d   = frame_b_q;
    busy_d      = busy;
    ldac_n_d    = 1'b1;
    overrun_d   = overrun;
    ovr_count_d = ovr_count;
    tx_start_c  = 1'b0;
    tx_frame_c  = frame_b_q;
    tick_drop_c = clk_sampling && (seq_q != SEQ_IDLE);

    case (seq_q)
      // Both channels are snapshotted here; later input changes cannot reach the DAC.
      SEQ_IDLE: begin
        if (clk_sampling) begin
          seq_d      = SEQ_FRAME_A;
          busy_d     = 1'b1;
          tx_start_c = 1'b1;
          tx_frame_c = build_frame(CH_A, enableA, dacA_word, GA);
          frame_b_d  = build_frame(CH_B, enableB, dacB_word, GA);
        end
      end

      SEQ_FRAME_A: begin
        if (tx_done_c) begin
          seq_d = SEQ_GAP;
          cnt_d = '0;
        end
      end

      // Start frame B on the last gap cycle so CS stays high exactly CS_GAP cycles.
      SEQ_GAP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GAP_LAST) begin
          seq_d      = SEQ_FRAME_B;
          tx_start_c = 1'b1;
        end
      end

      SEQ_FRAME_B: begin
        if (tx_done_c) begin
          seq_d = SEQ_LDAC;
          cnt_d = '0;
        end
      end

      // One settle cycle after CS rises, LDAC_W cycles low, one release cycle.
      SEQ_LDAC: begin
        cnt_d    = cnt_q + CNT_W'(1);
        ldac_n_d = (cnt_q >= LDAC_LEN);
        if (cnt_q == LDAC_LAST) begin
          seq_d  = SEQ_IDLE;
          busy_d = 1'b0;
        end
      end

      default: begin
        seq_d  = SEQ_IDLE;
        busy_d = 1'b0;
      end
    endcase

    // A drop coinciding with a clear leaves exactly that one drop recorded.
    if (tick_drop_c) begin
      overrun_d = 1'b1;
      if (ovr_clr) begin
        ovr_count_d = CNT_W'(1);
      end else if (ovr_count != OVR_MAX) begin
        ovr_count_d = ovr_count + CNT_W'(1);
      end
    end else if (ovr_clr) begin
      overrun_d   = 1'b0;
      ovr_count_d = '0;
    end
  end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Scoreboard bench: stimulus queues expected frames, negedge monitors decode SPI and check timing.
module tb_dac_frame_sequencer;

  localparam int D_MAIN    = 5;
  localparam int D_FAST    = 1;
  localparam int GAP       = 4;
  localparam int LW        = 3;
  localparam int BUSY_MAIN = 2 * 34 * D_MAIN + GAP + 1 + LW + 1;
  localparam int BUSY_FAST = 2 * 34 * D_FAST + GAP + 1 + LW + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, tick_f = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0, ovr_clr = 1'b0;
  logic [11:0] word_a = '0, word_b = '0;

  logic       cs_n, sck, mosi, ldac_n, busy, overrun;
  logic [7:0] ovr_count;
  logic       f_cs_n, f_sck, f_mosi, f_ldac_n, f_busy, f_overrun;
  logic [7:0] f_ovr_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ld_pulses = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_f[$];

  always #5 clk = ~clk;

  dac_frame_sequencer #(.SCK_DIV(D_MAIN), .CS_GAP(GAP), .LDAC_W(LW), .GAIN_1X(1)) u_dut (
    .clk(clk), .rst(rst), .clk_sampling(tick), .enableA(en_a), .enableB(en_b),
    .dacA_word(word_a), .dacB_word(word_b), .ovr_clr(ovr_clr),
    .spi_cs_n(cs_n), .spi_sck(sck), .spi_mosi(mosi), .dac_ldac_n(ldac_n),
    .busy(busy), .overrun(overrun), .ovr_count(ovr_count)
  );

  dac_frame_sequencer #(.SCK_DIV(D_FAST), .CS_GAP(GAP), .LDAC_W(LW), .GAIN_1X(1)) u_fast (
    .clk(clk), .rst(rst), .clk_sampling(tick_f), .enableA(en_a), .enableB(en_b),
    .dacA_word(word_a), .dacB_word(word_b), .ovr_clr(ovr_clr),
    .spi_cs_n(f_cs_n), .spi_sck(f_sck), .spi_mosi(f_mosi), .dac_ldac_n(f_ldac_n),
    .busy(f_busy), .overrun(f_overrun), .ovr_count(f_ovr_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs_n"},    32'(cs_n),      32'd1);
    check({tag, "_sck"},     32'(sck),       32'd0);
    check({tag, "_mosi"},    32'(mosi),      32'd0);
    check({tag, "_ldac_n"},  32'(ldac_n),    32'd1);
    check({tag, "_busy"},    32'(busy),      32'd0);
    check({tag, "_overrun"}, 32'(overrun),   32'd0);
    check({tag, "_count"},   32'(ovr_count), 32'd0);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    @(negedge clk);
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  // Main-DUT monitor: decodes MSB-first bits on SCK rises, checks frame, CS, LDAC and busy timing.
  logic [15:0] m_sreg = '0;
  int m_bits = 0, m_cs_len = 0, m_ld_len = 0, m_busy_len = 0, m_cs_rise = 0;
  logic m_cs_prev = 1'b1, m_sck_prev = 1'b0, m_ld_prev = 1'b1, m_busy_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_bits = 0; m_cs_len = 0; m_ld_len = 0; m_busy_len = 0;
      m_cs_prev = 1'b1; m_sck_prev = 1'b0; m_ld_prev = 1'b1; m_busy_prev = 1'b0;
    end else begin
      if (sck && !m_sck_prev) begin
        m_sreg = {m_sreg[14:0], mosi};
        m_bits++;
      end
      if (!cs_n) m_cs_len++;
      if (cs_n && !m_cs_prev) begin
        check("cs_low_len", 32'(m_cs_len), 32'(34 * D_MAIN));
        check("frame_bits", 32'(m_bits), 32'd16);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame: got=%h expected=none", m_sreg);
        end else begin
          check("frame", 32'(m_sreg), 32'(exp_q.pop_front()));
        end
        m_cs_rise = cyc; m_bits = 0; m_cs_len = 0;
      end
      if (!ldac_n && m_ld_prev) begin
        check("ldac_delay", 32'(cyc - m_cs_rise), 32'd1);
        ld_pulses++;
      end
      if (!ldac_n) m_ld_len++;
      if (ldac_n && !m_ld_prev) begin
        check("ldac_width", 32'(m_ld_len), 32'(LW));
        m_ld_len = 0;
      end
      if (busy) m_busy_len++;
      if (!busy && m_busy_prev) begin
        check("busy_len", 32'(m_busy_len), 32'(BUSY_MAIN));
        m_busy_len = 0;
      end
      m_cs_prev = cs_n; m_sck_prev = sck; m_ld_prev = ldac_n; m_busy_prev = busy;
    end
  end

  // Fast-DUT monitor (SCK_DIV=1).
  logic [15:0] f_sreg = '0;
  int f_bits = 0, f_cs_len = 0, f_busy_len = 0;
  logic f_cs_prev = 1'b1, f_sck_prev = 1'b0, f_busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      f_bits = 0; f_cs_len = 0; f_busy_len = 0;
      f_cs_prev = 1'b1; f_sck_prev = 1'b0; f_busy_prev = 1'b0;
    end else begin
      if (f_sck && !f_sck_prev) begin
        f_sreg = {f_sreg[14:0], f_mosi};
        f_bits++;
      end
      if (!f_cs_n) f_cs_len++;
      if (f_cs_n && !f_cs_prev) begin
        check("fast_cs_low_len", 32'(f_cs_len), 32'(34 * D_FAST));
        check("fast_frame_bits", 32'(f_bits), 32'd16);
        if (exp_f.size() == 0) begin
          total++; bad++;
          $display("FAIL fast_unexpected_frame: got=%h expected=none", f_sreg);
        end else begin
          check("fast_frame", 32'(f_sreg), 32'(exp_f.pop_front()));
        end
        f_bits = 0; f_cs_len = 0;
      end
      if (f_busy) f_busy_len++;
      if (!f_busy && f_busy_prev) begin
        check("fast_busy_len", 32'(f_busy_len), 32'(BUSY_FAST));
        f_busy_len = 0;
      end
      f_cs_prev = f_cs_n; f_sck_prev = f_sck; f_busy_prev = f_busy;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses_before;
    int n;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Both channels enabled; a tick on the final busy cycle must be dropped.
    word_a = 12'hABC; word_b = 12'h123; en_a = 1'b1; en_b = 1'b1;
    exp_q.push_back(16'h3ABC);
    exp_q.push_back(16'hB123);
    pulse_tick();
    check("busy_first", 32'(busy), 32'd1);
    repeat (BUSY_MAIN - 1) @(negedge clk);
    check("busy_last", 32'(busy), 32'd1);
    check("ldac_pulses_1", 32'(ld_pulses), 32'd1);
    pulse_tick();
    check("busy_after", 32'(busy), 32'd0);
    check("edge_overrun", 32'(overrun), 32'd1);
    check("edge_count", 32'(ovr_count), 32'd1);
    @(negedge clk);
    check("no_restart", 32'(busy), 32'd0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_count", 32'(ovr_count), 32'd0);

    // Channel B disabled; mid-frame input changes and a dropped tick must not leak through.
    word_a = 12'hABC; word_b = 12'hFFF; en_a = 1'b1; en_b = 1'b0;
    exp_q.push_back(16'h3ABC);
    exp_q.push_back(16'hA000);
    pulse_tick();
    repeat (50) @(negedge clk);
    word_a = 12'h555; en_a = 1'b0; word_b = 12'h321; en_b = 1'b1;
    repeat (49) @(negedge clk);
    pulse_tick();
    check("drop_overrun", 32'(overrun), 32'd1);
    check("drop_count", 32'(ovr_count), 32'd1);
    wait_idle(1000);
    check("ldac_pulses_2", 32'(ld_pulses), 32'd2);

    // Continuous ticks while busy saturate the count; clear coinciding with a drop yields 1.
    word_a = 12'h0F0; word_b = 12'h00F; en_a = 1'b1; en_b = 1'b1;
    exp_q.push_back(16'h30F0);
    exp_q.push_back(16'hB00F);
    tick = 1'b1;
    repeat (300) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    check("sat_count", 32'(ovr_count), 32'd255);
    check("sat_overrun", 32'(overrun), 32'd1);
    tick = 1'b1; ovr_clr = 1'b1;
    @(negedge clk);
    tick = 1'b0; ovr_clr = 1'b0;
    check("clr_drop_overrun", 32'(overrun), 32'd1);
    check("clr_drop_count", 32'(ovr_count), 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("clr2_count", 32'(ovr_count), 32'd0);
    wait_idle(1000);

    // Async reset during bit 7 of frame A: immediate reset values, no LDAC, clean restart.
    word_a = 12'h7E5; word_b = 12'h001;
    pulse_tick();
    repeat (66) @(negedge clk);
    check("abort_mid_frame", 32'(cs_n), 32'd0);
    pulses_before = ld_pulses;
    #2 rst = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("abort_no_ldac", 32'(ld_pulses), 32'(pulses_before));
    check("abort_idle", 32'(busy), 32'd0);
    exp_q.push_back(16'h37E5);
    exp_q.push_back(16'hB001);
    pulse_tick();
    wait_idle(1000);
    check("restart_ldac", 32'(ld_pulses), 32'(pulses_before + 1));

    // SCK_DIV=1 instance: 2-cycle SCK, 34-cycle CS windows, and a drop while busy.
    word_a = 12'h246; word_b = 12'h9DB; en_a = 1'b1; en_b = 1'b1;
    exp_f.push_back(16'h3246);
    exp_f.push_back(16'hB9DB);
    tick_f = 1'b1;
    @(negedge clk);
    tick_f = 1'b0;
    repeat (10) @(negedge clk);
    tick_f = 1'b1;
    @(negedge clk);
    tick_f = 1'b0;
    check("fast_overrun", 32'(f_overrun), 32'd1);
    check("fast_count", 32'(f_ovr_count), 32'd1);
    n = 0;
    while (f_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("fast_wait_idle", 32'(f_busy), 32'd0);
    repeat (5) @(negedge clk);

    check("main_queue_drained", 32'(exp_q.size()), 32'd0);
    check("fast_queue_drained", 32'(exp_f.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
